cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Round-robin arbiter for the single common data bus (CDB) that returns completed results to the reorder buffer. Each cycle it picks one ready result from the ALU reservation stations, branch reservation stations and the load/store queue, and grants it. It registers the winner onto `cdb_o` and returns a one-hot grant so the winning station can retire its entry. It sits between the execution-side stations and the reorder buffer's completion and broadcast path.

## Interface
- `width`, 32, data width of a result
- `alu_rs_size`, 8, number of ALU RS result slots
- `br_rs_size`, 3, number of branch RS result slots
- `n_req` (localparam), `alu_rs_size + br_rs_size + 1`; request index order is ALU 0..7, then BR 8..10, then LSQ 11
- `clk`  in  1  clock; all state changes on posedge
- `rst`  in  1  reset, synchronous, active-low
- `alu_rs_o`  in  sal_t [alu_rs_size]  ALU results; `.rdy` is the request, `.tag`/`.data` are the payload
- `br_rs_o`  in  sal_t [br_rs_size]  branch results, same encoding
- `lsq_o`  in  sal_t  LSQ result, same encoding
- `flush`  in  1  mispredict flush; kills this cycle's arbitration
- `rob_stall`  in  1  ROB cannot accept a completion this cycle
- `alu_grant`  out  [alu_rs_size]  combinational one-hot grant to the ALU slots
- `br_grant`  out  [br_rs_size]  combinational grant to the BR slots
- `lsq_grant`  out  1  combinational grant to the LSQ
- `cdb_o`  out  sal_t  registered winning result (tag 4 bits, rdy, data `width` bits)
- `contention_cnt`  out  16  saturating count of cycles with at least 2 requesters

## Operation
- **State:** `ptr` (clog2(n_req) bits, next index to favour), the `cdb_o` register, and `contention_cnt`.
- **Reset values** (rst==0 at posedge): `ptr`=0, `cdb_o`='{0,0,0}, `contention_cnt`=0. Grants are combinational from inputs and go all-zero whenever reset is asserted.
- **Arbitration** (combinational):
  - Form `req[n_req]` from the `.rdy` bits.
  - Search index `ptr`, `ptr+1`, … modulo `n_req`.
  - The first set bit wins and its grant bit is asserted. At most one grant bit across all three grant outputs.
- **Grant suppression:** no grant when `flush`, `rob_stall`, reset, or no request is active.
- **On a grant at posedge:**
  - `cdb_o` <= the winner's sal_t, with `rdy` forced to 1.
  - `ptr` <= (winner + 1) mod `n_req`. A winner of `n_req`-1 wraps `ptr` to 0.
- **Without a grant:** `cdb_o` <= '{0,0,0}; `ptr` unchanged. `flush` and `rob_stall` therefore both produce a bubble with `cdb_o.rdy`=0 the next cycle.
- **flush and rob_stall together:** treated as flush. No grant; `ptr` unchanged.
- **Requester contract:**
  - A requester keeps `.rdy`, `.tag` and `.data` stable until it sees its grant.
  - It drops the request at the posedge where its grant is high.
  - A request withdrawn without a grant is legal and is simply not considered.
- **contention_cnt:**
  - Increments by 1 at posedge when popcount(req) ≥ 2 and neither `flush` nor `rob_stall` is high.
  - Saturates at 16'hFFFF.
- **Reset mid-operation:** a pending `cdb_o` is discarded and the contention count is lost. Stations must be flushed by their own reset.

## Timing
- Request seen in cycle t → grant in cycle t (combinational) → `cdb_o` valid in cycle t+1.
- Each grant produces exactly one cycle of `cdb_o.rdy`=1.
- Throughput is one result per cycle. Back-to-back grants give continuous `cdb_o.rdy`=1 with a new tag each cycle.
- Fairness: a continuously asserted requester is granted within `n_req` cycles of non-stalled, non-flushed arbitration (at most 11 other grants first).
- No path from `cdb_o` to the grants. The critical path is req → priority search → grant.

## Test plan
- **Single requester, from reset:** `lsq_o`={tag 5, rdy 1, data 32'hDEAD_BEEF}. Required: `lsq_grant`=1 in the same cycle; next cycle `cdb_o`={5,1,DEADBEEF} and `ptr`=0 (wrap from 11).
- **All 12 requesting continuously, ptr=0:** grants go to indices 0,1,…,11,0 on consecutive cycles. `cdb_o.rdy` stays 1 for 12+ cycles and `contention_cnt` increments every cycle.
- **Round-robin after a grant:**
  - ALU slot 3 is granted, so `ptr`=4.
  - Then ALU 2 and BR 9 (index 9) request.
  - Required: index 9 wins first, then index 2.
- **flush:** ALU 0 requests while `flush`=1. Required: no grant, next-cycle `cdb_o.rdy`=0, `ptr` unchanged. Once `flush` drops, ALU 0 is granted.
- **rob_stall:** held for 3 cycles while 2 requesters are active. Required: no grants, `cdb_o.rdy`=0, `contention_cnt` unchanged. Arbitration resumes on the first cycle after release.
- **Saturation and reset:**
  - Preload `contention_cnt` to 16'hFFFE with 2 requesters active for 3 cycles; required value 16'hFFFF.
  - Then assert `rst`=0 for one posedge. Required: counter, `ptr` and `cdb_o` return to 0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: picks one ready ALU/BR/LSQ result per cycle,
// returns a combinational one-hot grant and registers the winner onto cdb_o.
package cdb_arbiter_pkg;
    localparam int unsigned CDB_WIDTH = 32;
    localparam int unsigned TAG_W     = 4;

    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        logic                 rdy;
        logic [CDB_WIDTH-1:0] data;
    } sal_t;
endpackage

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned width       = CDB_WIDTH,
    parameter int unsigned alu_rs_size = 8,
    parameter int unsigned br_rs_size  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  sal_t                   alu_rs_o [alu_rs_size],
    input  sal_t                   br_rs_o  [br_rs_size],
    input  sal_t                   lsq_o,
    input  logic                   flush,
    input  logic                   rob_stall,
    output logic [alu_rs_size-1:0] alu_grant,
    output logic [br_rs_size-1:0]  br_grant,
    output logic                   lsq_grant,
    output sal_t                   cdb_o,
    output logic [15:0]            contention_cnt
);
    localparam int unsigned NReq  = alu_rs_size + br_rs_size + 1;
    localparam int unsigned PtrW  = $clog2(NReq);
    localparam int unsigned CandW = PtrW + 1;
    localparam int unsigned CntW  = 16;

    sal_t               req_sal [NReq];
    logic [NReq-1:0]    req;
    logic [NReq-1:0]    grant_vec;
    logic [PtrW-1:0]    ptr_q, ptr_d;
    logic [PtrW-1:0]    win_idx;
    logic [CandW-1:0]   cand;
    logic               found;
    logic               grant_en;
    sal_t               win_sal;
    logic [width-1:0]   win_data;
    sal_t               cdb_q, cdb_d;
    logic [CntW-1:0]    cnt_q, cnt_d;

    // Flatten the three request sources into one index space: ALU, then BR, then LSQ.
    always_comb begin
        for (int unsigned i = 0; i < alu_rs_size; i++) req_sal[i] = alu_rs_o[i];
        for (int unsigned i = 0; i < br_rs_size; i++) req_sal[alu_rs_size + i] = br_rs_o[i];
        req_sal[NReq-1] = lsq_o;
        req = '0;
        for (int unsigned i = 0; i < NReq; i++) req[i] = req_sal[i].rdy;
    end

    // Rotating priority search starting at ptr_q.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NReq; k++) begin
            cand = CandW'(ptr_q) + CandW'(k);
            if (cand >= CandW'(NReq)) cand = cand - CandW'(NReq);
            if (!found && req[cand[PtrW-1:0]]) begin
                found   = 1'b1;
                win_idx = cand[PtrW-1:0];
            end
        end
    end

    always_comb begin
        grant_en  = rst && !flush && !rob_stall && found;
        grant_vec = '0;
        if (grant_en) grant_vec[win_idx] = 1'b1;
        alu_grant = grant_vec[alu_rs_size-1:0];
        br_grant  = grant_vec[alu_rs_size +: br_rs_size];
        lsq_grant = grant_vec[NReq-1];
    end

    // Next-state: winner payload onto the bus, pointer past the winner, contention counter.
    always_comb begin
        win_sal  = req_sal[win_idx];
        win_data = width'(win_sal.data);
        cdb_d    = '0;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        if (grant_en) begin
            cdb_d.tag  = win_sal.tag;
            cdb_d.rdy  = 1'b1;
            cdb_d.data = CDB_WIDTH'(win_data);
            ptr_d      = (win_idx == PtrW'(NReq - 1)) ? '0 : win_idx + PtrW'(1);
        end
        if (!flush && !rob_stall && ($countones(req) >= 2) && (cnt_q != {CntW{1'b1}}))
            cnt_d = cnt_q + CntW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
            cdb_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cdb_q <= cdb_d;
            cnt_q <= cnt_d;
        end
    end

    assign cdb_o          = cdb_q;
    assign contention_cnt = cnt_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed table, hand-written corner sequences and
// random traffic compared against a round-robin reference model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N = 12;

    logic        clk = 1'b0;
    logic        rst;
    sal_t        alu_rs [8];
    sal_t        br_rs  [3];
    sal_t        lsq;
    logic        flush;
    logic        rob_stall;
    logic [7:0]  alu_grant;
    logic [2:0]  br_grant;
    logic        lsq_grant;
    sal_t        cdb_o;
    logic [15:0] contention_cnt;

    int n_checks = 0;
    int n_errors = 0;

    int   m_ptr;
    int   m_cnt;
    sal_t m_cdb;
    int   last_win;

    cdb_arbiter #(.width(32), .alu_rs_size(8), .br_rs_size(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_rs_o       (alu_rs),
        .br_rs_o        (br_rs),
        .lsq_o          (lsq),
        .flush          (flush),
        .rob_stall      (rob_stall),
        .alu_grant      (alu_grant),
        .br_grant       (br_grant),
        .lsq_grant      (lsq_grant),
        .cdb_o          (cdb_o),
        .contention_cnt (contention_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] alu;
        logic [2:0] br;
        logic       lsq;
        logic       fl;
        logic       st;
        int         exp_win;
        int         exp_ptr;
    } vec_t;

    vec_t tbl [13];

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic sal_t slot(input int j);
        if (j < 8)       return alu_rs[j];
        else if (j < 11) return br_rs[j-8];
        else             return lsq;
    endfunction

    function automatic int n_req();
        int c = 0;
        for (int j = 0; j < N; j++) if (slot(j).rdy) c++;
        return c;
    endfunction

    // Reference: first ready index scanning ptr, ptr+1, ... modulo N; -1 when suppressed.
    function automatic int model_winner();
        if (!rst || flush || rob_stall) return -1;
        for (int k = 0; k < N; k++) begin
            int j = (m_ptr + k) % N;
            if (slot(j).rdy) return j;
        end
        return -1;
    endfunction

    // Decode the grant outputs: -1 none, -2 more than one, else the granted index.
    function automatic int actual_winner();
        logic [11:0] gv = {lsq_grant, br_grant, alu_grant};
        int w = -1;
        if ($countones(gv) > 1) return -2;
        for (int j = 0; j < N; j++) if (gv[j]) w = j;
        return w;
    endfunction

    task automatic set_reqs(input logic [7:0] am, input logic [2:0] bm, input logic lm);
        for (int i = 0; i < 8; i++) alu_rs[i] = '{tag: 4'(i), rdy: am[i], data: 32'hC0DE_0000 | 32'(i)};
        for (int i = 0; i < 3; i++) br_rs[i] = '{tag: 4'(8 + i), rdy: bm[i], data: 32'hC0DE_0000 | 32'(8 + i)};
        lsq = '{tag: 4'd11, rdy: lm, data: 32'hC0DE_000B};
    endtask

    // Entered at posedge+1 with inputs applied; returns at the following posedge+1.
    task automatic run_cycle(input string name);
        int exp_w;
        int act_w;
        #3;
        exp_w = model_winner();
        act_w = actual_winner();
        check_int({name, " grant"}, act_w, exp_w);
        last_win = act_w;
        if (!rst) begin
            m_ptr = 0;
            m_cdb = '0;
            m_cnt = 0;
        end else begin
            if (exp_w >= 0) begin
                m_cdb     = slot(exp_w);
                m_cdb.rdy = 1'b1;
                m_ptr     = (exp_w + 1) % N;
            end else begin
                m_cdb = '0;
            end
            if (!flush && !rob_stall && n_req() >= 2 && m_cnt < 65535) m_cnt++;
        end
        @(posedge clk);
        #1;
        check_vec({name, " cdb_o"}, 48'(cdb_o), 48'(m_cdb));
        check_int({name, " contention_cnt"}, int'(contention_cnt), m_cnt);
        check_int({name, " ptr"}, int'(dut.ptr_q), m_ptr);
    endtask

    task automatic do_reset(input string name);
        rst = 1'b0;
        set_reqs(8'h81, 3'b010, 1'b1);
        run_cycle(name);
        rst = 1'b1;
        set_reqs('0, '0, 1'b0);
    endtask

    initial begin
        int   saved_cnt;
        sal_t exp_cdb;

        tbl[0]  = '{8'h08, 3'b000, 1'b0, 1'b0, 1'b0,  3,  4};
        tbl[1]  = '{8'h04, 3'b010, 1'b0, 1'b0, 1'b0,  9, 10};
        tbl[2]  = '{8'h04, 3'b000, 1'b0, 1'b0, 1'b0,  2,  3};
        tbl[3]  = '{8'h01, 3'b000, 1'b0, 1'b1, 1'b0, -1,  3};
        tbl[4]  = '{8'h01, 3'b000, 1'b0, 1'b0, 1'b0,  0,  1};
        tbl[5]  = '{8'h21, 3'b000, 1'b0, 1'b0, 1'b1, -1,  1};
        tbl[6]  = '{8'h20, 3'b000, 1'b1, 1'b0, 1'b0,  5,  6};
        tbl[7]  = '{8'h01, 3'b000, 1'b1, 1'b0, 1'b0, 11,  0};
        tbl[8]  = '{8'h01, 3'b000, 1'b0, 1'b1, 1'b1, -1,  0};
        tbl[9]  = '{8'h00, 3'b000, 1'b0, 1'b0, 1'b0, -1,  0};
        tbl[10] = '{8'h00, 3'b101, 1'b0, 1'b0, 1'b0,  8,  9};
        tbl[11] = '{8'h01, 3'b100, 1'b0, 1'b0, 1'b0, 10, 11};
        tbl[12] = '{8'h01, 3'b000, 1'b0, 1'b0, 1'b0,  0,  1};

        m_ptr = 0; m_cnt = 0; m_cdb = '0; last_win = -1;
        flush = 1'b0; rob_stall = 1'b0; rst = 1'b0;
        set_reqs('0, '0, 1'b0);
        @(posedge clk);
        #1;
        do_reset("por");

        // Single LSQ requester straight out of reset.
        lsq = '{tag: 4'd5, rdy: 1'b1, data: 32'hDEAD_BEEF};
        run_cycle("single_lsq");
        check_int("single_lsq lsq_grant", last_win, 11);
        exp_cdb = '{tag: 4'd5, rdy: 1'b1, data: 32'hDEAD_BEEF};
        check_vec("single_lsq cdb value", 48'(cdb_o), 48'(exp_cdb));
        check_int("single_lsq ptr wrap", int'(dut.ptr_q), 0);
        lsq.rdy = 1'b0;

        // All twelve requesting back to back.
        set_reqs(8'hFF, 3'b111, 1'b1);
        for (int k = 0; k < 13; k++) begin
            run_cycle("all12");
            check_int("all12 order", last_win, k % N);
            check_int("all12 cdb rdy", int'(cdb_o.rdy), 1);
        end

        do_reset("reset_before_table");
        for (int v = 0; v < 13; v++) begin
            set_reqs(tbl[v].alu, tbl[v].br, tbl[v].lsq);
            flush     = tbl[v].fl;
            rob_stall = tbl[v].st;
            run_cycle($sformatf("tbl%0d", v));
            check_int($sformatf("tbl%0d win", v), last_win, tbl[v].exp_win);
            check_int($sformatf("tbl%0d ptr", v), int'(dut.ptr_q), tbl[v].exp_ptr);
        end
        flush = 1'b0; rob_stall = 1'b0;

        // rob_stall held for three cycles with two requesters.
        set_reqs(8'h12, 3'b000, 1'b0);
        saved_cnt = m_cnt;
        rob_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            run_cycle("stall");
            check_int("stall cdb rdy", int'(cdb_o.rdy), 0);
            check_int("stall cnt held", int'(contention_cnt), saved_cnt);
        end
        rob_stall = 1'b0;
        run_cycle("stall_release");
        check_int("stall_release win", last_win, 1);

        // Counter saturation from a preloaded near-full value.
        set_reqs('0, '0, 1'b0);
        force dut.cnt_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.cnt_q;
        m_cdb = '0;
        m_cnt = 65534;
        check_int("preload cnt", int'(contention_cnt), 65534);
        set_reqs(8'h00, 3'b011, 1'b0);
        for (int k = 0; k < 3; k++) run_cycle("saturate");
        check_int("saturate value", int'(contention_cnt), 65535);
        do_reset("reset_mid_op");
        check_int("reset cnt", int'(contention_cnt), 0);
        check_int("reset ptr", int'(dut.ptr_q), 0);

        // Random traffic against the reference model.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 8; i++)
                alu_rs[i] = '{tag: 4'($urandom_range(0, 15)), rdy: ($urandom_range(0, 2) == 0), data: $urandom};
            for (int i = 0; i < 3; i++)
                br_rs[i] = '{tag: 4'($urandom_range(0, 15)), rdy: ($urandom_range(0, 2) == 0), data: $urandom};
            lsq       = '{tag: 4'($urandom_range(0, 15)), rdy: ($urandom_range(0, 2) == 0), data: $urandom};
            flush     = ($urandom_range(0, 7) == 0);
            rob_stall = ($urandom_range(0, 7) == 0);
            rst       = ($urandom_range(0, 63) != 0);
            run_cycle("rand");
        end
        rst = 1'b1; flush = 1'b0; rob_stall = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
